// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling,
// valid/ready byte output and framing/overrun pulses. Define UART_RX_PARITY_EN for even parity.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  // CLKS_PER_BIT must be at least 4 so the half-bit reload stays positive.
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             framing_err_q, framing_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             rx_s;
  logic             tick_c;
  logic             byte_ok_c;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign rx_s   = sync_q[1];
  assign tick_c = (cnt_q == '0);

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[0], rx};
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready;
    framing_err_d = 1'b0;
    overrun_d     = 1'b0;
    byte_ok_c     = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
    byte_ok_c     = !par_bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = CNT_FULL;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_c) begin
          par_bad_d = rx_s ^ (^shift_q);
          cnt_d     = CNT_FULL;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick_c) begin
          state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          if (!rx_s) begin
            framing_err_d = 1'b1;
            state_d       = S_BREAK;
          end else if (byte_ok_c) begin
            // A same-cycle accept frees the slot, so the new byte replaces the old one.
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sync_q        <= 2'b11;
      cnt_q         <= '0;
      bit_q         <= 3'd0;
      shift_q       <= 8'd0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame table, hand sequences and random frames against a
// frame-level timing model of uart_rx (10 clocks per bit).
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int C = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 98 + C;
`else
  localparam int LAT = 98;
`endif
  localparam int BIG = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .framing_err(framing_err),
    .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Frame-level model: each frame's stop sample lands LAT edges after its start edge.
  typedef struct {
    int         edge_no;
    logic [7:0] data;
    bit         stop;
    bit         par_ok;
  } ev_t;
  ev_t        evq[$];
  logic [7:0] m_data = 8'd0;
  bit         m_valid = 1'b0;
  int         m_bstart = 0;
  int         m_bend = 0;
  bit         rand_ready = 1'b0;

  int rise_cnt, rise_cyc, ferr_cnt, ovr_cnt, vhi_cnt, busy_cnt, frame_start;
  bit prev_valid = 1'b0;
`ifdef UART_RX_PARITY_EN
  int perr_cnt;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt = 0; rise_cyc = 0; ferr_cnt = 0; ovr_cnt = 0; vhi_cnt = 0; busy_cnt = 0;
`ifdef UART_RX_PARITY_EN
    perr_cnt = 0;
`endif
  endtask

  // One clock: advance the model at the edge, then compare every output #1 later.
  task automatic tick();
    ev_t ev;
    bit  acc, nv, e_ferr, e_ovr, e_busy;
`ifdef UART_RX_PARITY_EN
    bit  e_perr;
    e_perr = 1'b0;
`endif
    @(posedge clk);
    cyc++;
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    if (!reset) begin
      m_valid = 1'b0;
      m_data  = 8'd0;
      m_bend  = 0;
      evq.delete();
    end else begin
      acc = m_valid && rx_ready;
      nv  = m_valid && !rx_ready;
      if (evq.size() > 0 && evq[0].edge_no == cyc) begin
        ev = evq.pop_front();
`ifdef UART_RX_PARITY_EN
        e_perr = !ev.par_ok;
`endif
        if (!ev.stop) e_ferr = 1'b1;
        else if (ev.par_ok) begin
          if (!m_valid || acc) begin
            m_data = ev.data;
            nv     = 1'b1;
          end else begin
            e_ovr = 1'b1;
          end
        end
      end
      m_valid = nv;
    end
    e_busy = (cyc >= m_bstart) && (cyc < m_bend);
    #1;
    chk("rx_valid", int'(rx_valid), int'(m_valid));
    chk("rx_data", int'(rx_data), int'(m_data));
    chk("framing_err", int'(framing_err), int'(e_ferr));
    chk("overrun", int'(overrun), int'(e_ovr));
    chk("busy", int'(busy), int'(e_busy));
`ifdef UART_RX_PARITY_EN
    chk("parity_err", int'(parity_err), int'(e_perr));
    perr_cnt += int'(parity_err);
`endif
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
    ferr_cnt += int'(framing_err);
    ovr_cnt  += int'(overrun);
    vhi_cnt  += int'(rx_valid);
    busy_cnt += int'(busy);
    if (rand_ready) rx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok,
                            input int hold_bits, input int gap);
    ev_t ev;
    frame_start = cyc;
    ev.edge_no = cyc + LAT;
    ev.data    = d;
    ev.stop    = stop;
    ev.par_ok  = par_ok;
    evq.push_back(ev);
    m_bstart = cyc + 3;
    m_bend   = stop ? cyc + LAT : BIG;
    rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) tick();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ !par_ok;
    repeat (C) tick();
`endif
    rx = stop;
    repeat (C) tick();
    if (!stop) begin
      repeat (hold_bits * C) tick();
      rx = 1'b1;
      m_bend = cyc + 3;
    end
    repeat (gap) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         ready;
    int         hold_bits;
    logic [7:0] exp_data;
    bit         exp_valid;
    int         exp_rise;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic [7:0] d;
    bit stop, pok;

    vt[0] = '{8'h55, 1'b1, 1'b1, 0,  8'h55, 1'b0, 1, 0, 0};
    vt[1] = '{8'hA3, 1'b1, 1'b0, 0,  8'hA3, 1'b1, 1, 0, 0};
    vt[2] = '{8'h0F, 1'b1, 1'b0, 0,  8'hA3, 1'b1, 0, 0, 1};
    vt[3] = '{8'h81, 1'b0, 1'b1, 30, 8'hA3, 1'b0, 0, 1, 0};
    vt[4] = '{8'h42, 1'b1, 1'b1, 0,  8'h42, 1'b0, 1, 0, 0};
    vt[5] = '{8'hC5, 1'b1, 1'b0, 0,  8'hC5, 1'b1, 1, 0, 0};

    clear_mon();
    repeat (4) tick();
    chk("reset_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (2 * C) tick();

    for (int i = 0; i < 6; i++) begin
      rx_ready = vt[i].ready;
      if (i == 3) begin
        tick();
        chk("ready_clears_valid", int'(rx_valid), 0);
      end
      clear_mon();
      send_frame(vt[i].data, vt[i].stop, 1'b1, vt[i].hold_bits, 2 * C);
      chk("vec_data", int'(rx_data), int'(vt[i].exp_data));
      chk("vec_valid", int'(rx_valid), int'(vt[i].exp_valid));
      chk("vec_rise", rise_cnt, vt[i].exp_rise);
      chk("vec_ferr", ferr_cnt, vt[i].exp_ferr);
      chk("vec_ovr", ovr_cnt, vt[i].exp_ovr);
      if (vt[i].exp_rise != 0) chk("vec_latency", rise_cyc - frame_start, LAT);
      if (i == 0) chk("valid_width", vhi_cnt, 1);
    end

    // Short low glitch: busy only until the mid-start sample
    rx_ready = 1'b1;
    tick();
    clear_mon();
    m_bstart = cyc + 3;
    m_bend   = cyc + 8;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (2 * C) tick();
    chk("glitch_rise", rise_cnt, 0);
    chk("glitch_ferr", ferr_cnt, 0);
    chk("glitch_busy_cycles", busy_cnt, 5);

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x3C
    rx_ready = 1'b0;
    tick();
    m_bstart = cyc + 3;
    m_bend   = BIG;
    rx = 1'b0;
    repeat (C) tick();
    rx = 1'b1;
    repeat (4 * C + C / 2) tick();
    reset = 1'b0;
    #1;
    chk("reset_async_valid", int'(rx_valid), 0);
    chk("reset_async_busy", int'(busy), 0);
    repeat (5) tick();
    chk("reset_data", int'(rx_data), 0);
    chk("reset_valid", int'(rx_valid), 0);
    reset = 1'b1;
    rx_ready = 1'b1;
    repeat (4 * C) tick();
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b1, 0, 2 * C);
    chk("post_reset_rise", rise_cnt, 1);
    chk("post_reset_data", int'(rx_data), 8'h3C);

`ifdef UART_RX_PARITY_EN
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, 0, 2 * C);
    chk("par_good_data", int'(rx_data), 8'h07);
    chk("par_good_rise", rise_cnt, 1);
    chk("par_good_perr", perr_cnt, 0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 0, 2 * C);
    chk("par_bad_rise", rise_cnt, 0);
    chk("par_bad_perr", perr_cnt, 1);
`endif

    // Random frames, back-to-back gaps, random or stalled consumer
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      pok  = ($urandom_range(0, 5) != 0);
`else
      pok  = 1'b1;
`endif
      rand_ready = ($urandom_range(0, 2) != 0);
      if (!rand_ready) rx_ready = 1'b0;
      if (stop) send_frame(d, 1'b1, pok, 0, int'($urandom_range(0, 12)));
      else      send_frame(d, 1'b0, pok, int'($urandom_range(0, 3)), C + int'($urandom_range(0, 5)));
    end
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    repeat (2 * C) tick();
    chk("final_valid_drained", int'(rx_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver, the receive-side counterpart of `uart_tx`, for the iCE40 board designs. It synchronizes the asynchronous serial line and samples each bit at mid-period. It delivers 8N1 bytes through a valid/ready handshake to consumer logic such as echo/loopback tops, and flags framing and overrun errors.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line bit rate.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ / BAUD_RATE`, integer truncation; must be ≥ 4.
- Ports:
  - `clk` in 1: system clock; all logic on rising edge.
  - `reset` in 1: asynchronous, active-low reset.
  - `rx` in 1: serial input; idle high; asynchronous to `clk`.
  - `rx_data` out 8: received byte; stable while `rx_valid`.
  - `rx_valid` out 1: byte available.
  - `rx_ready` in 1: consumer accepts the byte when `rx_valid && rx_ready`.
  - `framing_err` out 1: one-cycle pulse; stop bit sampled low.
  - `overrun` out 1: one-cycle pulse; a byte completed while `rx_valid` was still set.
  - `busy` out 1: state is not IDLE.

## Operation
- Synchronizer:
  - `rx` passes through 2 flops, reset value 1.
  - All FSM decisions use the synchronized value `rx_s`.
- States: IDLE, START, DATA, STOP, BREAK. `PARITY` is added under the macro.
- IDLE:
  - `rx_s == 0` → START; bit counter cleared to `CLKS_PER_BIT/2 - 1`.
- START:
  - When the counter expires, sample `rx_s`.
  - Sample 0 → DATA.
  - Sample 1 → IDLE (glitch rejected, no error).
- DATA:
  - Sample every `CLKS_PER_BIT` cycles, LSB first, into a shift register.
  - After the 8th bit → STOP.
- STOP, sample after `CLKS_PER_BIT` cycles:
  - Sample 1, `rx_valid` 0: load `rx_data`, set `rx_valid`, go to IDLE.
  - Sample 1, `rx_valid` 1: pulse `overrun`, drop the new byte, keep the old `rx_data`/`rx_valid`, go to IDLE.
  - Sample 0: pulse `framing_err`, discard the byte, go to BREAK.
- BREAK:
  - Wait for `rx_s == 1`, then → IDLE. This prevents a held-low line from retriggering reception.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready`.
  - If a load (valid set) and an accept coincide in the same cycle, the new byte is loaded and `rx_valid` stays 1. The old byte is considered consumed; no overrun.
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `framing_err` = 0, `overrun` = 0, `busy` = 0, state IDLE.
  - Synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately. After release the block waits in IDLE for the next falling edge; a partially received frame's tail bits can look like a start bit and are handled by the normal START/STOP checks.

## Timing
- Counter width: `$clog2(CLKS_PER_BIT)`; the counter reloads with `CLKS_PER_BIT - 1` on each sample.
- Latency:
  - `rx_valid` rises `2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1` cycles after the `rx` falling edge at the pin.
  - Add `CLKS_PER_BIT` when parity is enabled.
- Error pulses assert one cycle after the offending sample and last exactly 1 cycle.
- Back-to-back frames: the next start bit may begin immediately after the stop bit's mid-point. The FSM is back in IDLE half a bit before the next start edge.
- Throughput: one byte per 10 bit periods (11 with parity).

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined:
    - A PARITY state sits between DATA and STOP and samples one even-parity bit.
    - Adds output `parity_err` (1 bit, reset 0). It pulses for one cycle at the stop sample if the parity mismatched.
    - The byte is discarded on mismatch; this does not affect the overrun logic.
  - Undefined: 8N1 only; no `parity_err` port.

## Test plan
Bench parameters: `CLK_FREQ` 1_000_000, `BAUD_RATE` 100_000 (10 clocks per bit).
- Send 0x55 8N1, `rx_ready` held 1 → `rx_valid` pulses exactly 1 cycle with `rx_data`=0x55, 98 cycles after the falling edge.
- Send 0xA3 with `rx_ready`=0, then send 0x0F → `rx_data` stays 0xA3, `overrun` pulses once. Raising `rx_ready` clears `rx_valid` on the next cycle.
- Drive `rx` low for 3 cycles, then high → no `rx_valid`, no error, `busy` returns to 0 at the mid-start sample.
- Send 0x81 with stop bit 0 and hold the line low for 30 bit periods → one `framing_err` pulse only. The following valid 0x42 is received correctly after the line returns high.
- Assert `reset` (0) during bit 4 of 0xFF, release it, then send 0x3C → all outputs 0 during reset; 0x3C received.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 1 → `rx_data`=0x07. Send 0x07 with parity bit 0 → `parity_err` pulse and no `rx_valid`.
